// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the MIPS Avalon load/store path.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Lane k carries byte offset k within the aligned word.
  function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: lane_enable = 4'b0001 << off;
      SZ_HALF: lane_enable = 4'b0011 << off;
      default: lane_enable = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mips_avalon_lsu_lane_align.sv
// Lane steering: store placement (IS_LOAD=0) or load extract/swap/extend (IS_LOAD=1).
module mips_avalon_lsu_lane_align
  import mips_bus_pkg::*;
#(
  parameter bit SWAP_BYTES = 1'b1,
  parameter bit IS_LOAD    = 1'b0
) (
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_signed,
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

  logic [31:0] w_sw;
  logic [31:0] w_sh;
  logic [15:0] w_half;
  logic [31:0] w_store;
  logic [31:0] w_load;

  // Byte order conversion on the right-justified core view.
  always_comb begin
    w_sw = i_data;
    if (SWAP_BYTES) begin
      case (i_size)
        SZ_HALF: w_sw = {i_data[31:16], i_data[7:0], i_data[15:8]};
        SZ_WORD: w_sw = {i_data[7:0], i_data[15:8], i_data[23:16], i_data[31:24]};
        default: w_sw = i_data;
      endcase
    end
  end

  always_comb begin
    case (i_size)
      SZ_BYTE: w_store = {4{w_sw[7:0]}};
      SZ_HALF: w_store = {2{w_sw[15:0]}};
      default: w_store = w_sw;
    endcase
  end

  // Loads shift the selected lane down first, then swap within the halfword.
  always_comb begin
    w_sh   = i_data >> {i_off, 3'b000};
    w_half = SWAP_BYTES ? {w_sh[7:0], w_sh[15:8]} : w_sh[15:0];
    case (i_size)
      SZ_BYTE: w_load = {{24{i_signed & w_sh[7]}}, w_sh[7:0]};
      SZ_HALF: w_load = {{16{i_signed & w_half[15]}}, w_half};
      default: w_load = w_sw;
    endcase
  end

  assign o_data = IS_LOAD ? w_load : w_store;

endmodule

// File: rtl/mips_avalon_lsu.sv
// Avalon-MM master load/store unit: one outstanding core request, registered bus cycle.
module mips_avalon_lsu
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter bit SWAP_BYTES = 1'b1,
  parameter int TIMEOUT    = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic [31:0]       readdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_t        r_state, w_next;
  logic              r_read, r_write;
  logic [ADDR_W-1:0] r_address;
  logic [31:0]       r_writedata;
  logic [3:0]        r_byteenable;
  logic [1:0]        r_size, r_off;
  logic              r_signed;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_resp_rdata;
  logic              r_resp_err;

  logic              w_bad, w_tmo;
  logic [31:0]       w_store, w_load;

  assign w_bad = (req_size == 2'd3) ||
                 (req_size == SZ_HALF && req_addr[0]) ||
                 (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
  assign w_tmo = (TIMEOUT != 0) && waitrequest && (r_cnt == CNT_W'(TIMEOUT - 1));

  mips_avalon_lsu_lane_align #(.SWAP_BYTES(SWAP_BYTES), .IS_LOAD(1'b0)) u_store (
    .i_size(req_size), .i_off(req_addr[1:0]), .i_signed(req_signed),
    .i_data(req_wdata), .o_data(w_store)
  );

  mips_avalon_lsu_lane_align #(.SWAP_BYTES(SWAP_BYTES), .IS_LOAD(1'b1)) u_load (
    .i_size(r_size), .i_off(r_off), .i_signed(r_signed),
    .i_data(readdata), .o_data(w_load)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = w_bad ? RESP : BUS;
      BUS:     if (!waitrequest || w_tmo) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_address    <= '0;
      r_writedata  <= '0;
      r_byteenable <= '0;
      r_size       <= '0;
      r_off        <= '0;
      r_signed     <= 1'b0;
      r_cnt        <= '0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (req_valid) begin
          r_size   <= req_size;
          r_off    <= req_addr[1:0];
          r_signed <= req_signed;
          r_cnt    <= '0;
          if (w_bad) begin
            // Rejected requests never reach the bus.
            r_resp_err   <= 1'b1;
            r_resp_rdata <= '0;
          end else begin
            r_address    <= {req_addr[ADDR_W-1:2], 2'b00};
            r_byteenable <= lane_enable(req_size, req_addr[1:0]);
            r_writedata  <= w_store;
            r_read       <= ~req_write;
            r_write      <= req_write;
          end
        end
        BUS: begin
          if (!waitrequest) begin
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= r_write ? 32'd0 : w_load;
          end else if (w_tmo) begin
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign address    = r_address;
  assign read       = r_read;
  assign write      = r_write;
  assign writedata  = r_writedata;
  assign byteenable = r_byteenable;

endmodule
